// File: rtl/dt_peak_scan_if.sv
// rtl/dt_peak_scan_if.sv - result-memory read bus between the peak scanner and the distance map
interface dt_peak_scan_if #(
   parameter int ADDR_W = 14
);
   logic              res_rd;
   logic [ADDR_W-1:0] res_addr;
   logic [7:0]        res_di;

   modport master (output res_rd, output res_addr, input res_di);
   modport slave  (input res_rd, input res_addr, output res_di);
endinterface

// File: rtl/dt_peak_scan.sv
// rtl/dt_peak_scan.sv - scans the distance map for its peak value, first peak address,
// peak multiplicity and foreground pixel count
module dt_peak_scan #(
   parameter int N_PIX  = 16384,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   dt_peak_scan_if.master    mem,
   output logic              busy,
   output logic              done,
   output logic [7:0]        max_dist,
   output logic [ADDR_W-1:0] max_addr,
   output logic [14:0]       max_count,
   output logic [14:0]       fg_count
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] tag;
   logic              valid;

   always_comb begin
      state_nx     = state;
      mem.res_rd   = 1'b0;
      mem.res_addr = '0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = READ;
         READ: begin
            mem.res_rd   = 1'b1;
            mem.res_addr = addr;
            busy         = 1'b1;
            if (addr == LAST_ADDR) state_nx = DRAIN;
         end
         DRAIN: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (!start) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // valid/tag follow the issued address by one cycle, lining up with res_di
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr      <= '0;
         tag       <= '0;
         valid     <= 1'b0;
         max_dist  <= '0;
         max_addr  <= '0;
         max_count <= '0;
         fg_count  <= '0;
      end else begin
         state <= state_nx;
         valid <= (state == READ);
         tag   <= addr;
         if (state == IDLE && start) begin
            addr      <= '0;
            max_dist  <= '0;
            max_addr  <= '0;
            max_count <= '0;
            fg_count  <= '0;
         end else if (state == READ) begin
            addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
         end
         if (valid) begin
            if (mem.res_di > max_dist) begin
               max_dist  <= mem.res_di;
               max_addr  <= tag;
               max_count <= 15'd1;
            end else if (mem.res_di == max_dist) begin
               max_count <= max_count + 15'd1;
            end
            if (mem.res_di != 8'd0) fg_count <= fg_count + 15'd1;
         end
      end
   end
endmodule

// File: tb/tb_dt_peak_scan.sv
// tb/tb_dt_peak_scan.sv - self-checking bench for dt_peak_scan
module tb_dt_peak_scan;
   localparam int N_PIX  = 16384;
   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              busy, done;
   logic [7:0]        max_dist;
   logic [ADDR_W-1:0] max_addr;
   logic [14:0]       max_count, fg_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem_arr [0:N_PIX-1];
   int reads    = 0;
   int addr_err = 0;
   int idle_err = 0;
   int exp_addr = 0;

   always #5 clk = ~clk;

   dt_peak_scan_if #(.ADDR_W(ADDR_W)) bus ();

   dt_peak_scan #(.N_PIX(N_PIX), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mem       (bus.master),
      .busy      (busy),
      .done      (done),
      .max_dist  (max_dist),
      .max_addr  (max_addr),
      .max_count (max_count),
      .fg_count  (fg_count)
   );

   // memory model: data one cycle after the strobe, filler otherwise
   always @(posedge clk) begin
      if (bus.res_rd) begin
         bus.res_di <= mem_arr[bus.res_addr];
         if (int'(bus.res_addr) != exp_addr) addr_err <= addr_err + 1;
         exp_addr <= exp_addr + 1;
         reads    <= reads + 1;
      end else begin
         bus.res_di <= 8'hA5;
         exp_addr   <= 0;
         if (bus.res_addr != '0) idle_err <= idle_err + 1;
      end
   end

   typedef struct {
      int          pat;
      logic [7:0]  md;
      logic [13:0] ma;
      logic [14:0] mc;
      logic [14:0] fc;
   } vec_t;

   vec_t vecs [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_pat(input int pat);
      for (int i = 0; i < N_PIX; i++) mem_arr[i] = 8'd0;
      case (pat)
         1: begin mem_arr[5000] = 8'd7; mem_arr[5001] = 8'd3; end
         2: begin mem_arr[300] = 8'd12; mem_arr[9000] = 8'd12; mem_arr[400] = 8'd11; end
         3: mem_arr[16383] = 8'd255;
         default: ;
      endcase
   endtask

   task automatic check_results(input string tag_s, input logic [7:0] md, input logic [13:0] ma,
                                input logic [14:0] mc, input logic [14:0] fc);
      chk({tag_s, " max_dist"},  32'(max_dist),  32'(md));
      chk({tag_s, " max_addr"},  32'(max_addr),  32'(ma));
      chk({tag_s, " max_count"}, 32'(max_count), 32'(mc));
      chk({tag_s, " fg_count"},  32'(fg_count),  32'(fc));
   endtask

   // counts edges starting with the one that samples start in IDLE; leaves start high
   task automatic run_scan(input string tag_s);
      int cnt;
      int r0;
      r0 = reads;
      cnt = 0;
      @(negedge clk);
      start = 1'b1;
      while (cnt < N_PIX + 20) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt == 1) begin
            chk({tag_s, " busy after start"}, 32'(busy), 32'd1);
            chk({tag_s, " cleared max_dist"}, 32'(max_dist), 32'd0);
            chk({tag_s, " cleared fg_count"}, 32'(fg_count), 32'd0);
         end
         if (done) break;
      end
      chk({tag_s, " latency"}, 32'(cnt), 32'(N_PIX + 2));
      chk({tag_s, " read count"}, 32'(reads - r0), 32'(N_PIX));
   endtask

   task automatic idle_cycles(input string tag_s, input int n);
      int bad;
      bad = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (busy || done || bus.res_rd || bus.res_addr != '0) bad++;
      end
      chk({tag_s, " stays idle"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int cnt;
      int r0;
      int bad;

      vecs[0] = '{pat: 0, md: 8'd0,   ma: 14'd0,     mc: 15'd16384, fc: 15'd0};
      vecs[1] = '{pat: 3, md: 8'd255, ma: 14'd16383, mc: 15'd1,     fc: 15'd1};

      reset = 1'b0;
      start = 1'b0;
      load_pat(0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset res_rd", 32'(bus.res_rd), 32'd0);
      chk("reset res_addr", 32'(bus.res_addr), 32'd0);
      check_results("reset", 8'd0, 14'd0, 15'd0, 15'd0);
      @(negedge clk);
      reset = 1'b1;
      idle_cycles("post reset", 5);

      for (int v = 0; v < 2; v++) begin
         load_pat(vecs[v].pat);
         run_scan($sformatf("vec%0d", v));
         check_results($sformatf("vec%0d", v), vecs[v].md, vecs[v].ma, vecs[v].mc, vecs[v].fc);
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d done drop", v), 32'(done), 32'd0);
      end

      // reset pulse mid-scan, then a complete rescan
      load_pat(2);
      @(negedge clk);
      start = 1'b1;
      cnt = 0;
      while (cnt < 20000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (bus.res_rd && bus.res_addr == 14'd8000) break;
      end
      chk("reached addr 8000", 32'(bus.res_addr), 32'd8000);
      #2;
      reset = 1'b0;
      #1;
      chk("async reset busy", 32'(busy), 32'd0);
      chk("async reset res_rd", 32'(bus.res_rd), 32'd0);
      chk("async reset res_addr", 32'(bus.res_addr), 32'd0);
      check_results("async reset", 8'd0, 14'd0, 15'd0, 15'd0);
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle_cycles("after mid reset", 5);
      run_scan("rescan");
      check_results("rescan", 8'd12, 14'd300, 15'd2, 15'd3);

      // start held high in DONE: no new reads, results held
      r0 = reads;
      bad = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (!done || bus.res_rd || max_dist != 8'd12) bad++;
      end
      chk("hold in done", 32'(bad), 32'd0);
      chk("hold no reads", 32'(reads - r0), 32'd0);

      load_pat(1);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("done low in idle", 32'(done), 32'd0);
      run_scan("restart");
      check_results("restart", 8'd7, 14'd5000, 15'd1, 15'd2);

      chk("address sequence errors", 32'(addr_err), 32'd0);
      chk("idle address errors", 32'(idle_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dt_peak_scan.md
DT_PEAK_SCAN -- requirements
Module: dt_peak_scan

Interface
REQ-001 Parameter: N_PIX, default 16384, number of result-memory bytes scanned (128x128 distance map).
REQ-002 Parameter: ADDR_W, default 14, width of res_addr.
REQ-003 Port: clk  in  1  clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  level request to scan; driven by the distance-transform done.
REQ-006 Port: res_rd  out  1  read strobe to result memory.
REQ-007 Port: res_addr  out  ADDR_W  result-memory read address.
REQ-008 Port: res_di  in  8  read data, valid exactly one cycle after the res_rd/res_addr cycle.
REQ-009 Port: busy  out  1  high in READ and DRAIN.
REQ-010 Port: done  out  1  high while in DONE.
REQ-011 Port: max_dist  out  8  largest distance value found.
REQ-012 Port: max_addr  out  ADDR_W  lowest address holding max_dist.
REQ-013 Port: max_count  out  15  number of pixels equal to max_dist.
REQ-014 Port: fg_count  out  15  number of non-zero pixels.

Function
REQ-015 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-016 IDLE: start=1 -> READ next cycle; max_dist, max_addr, max_count, fg_count cleared to 0 on that same edge.
REQ-017 READ: res_rd=1; res_addr=0 on first READ cycle, +1 each cycle; after address N_PIX-1 is issued -> DRAIN.
REQ-018 DRAIN: res_rd=0, one cycle, processes datum of address N_PIX-1; -> DONE.
REQ-019 DONE: done=1; stay while start=1; start=0 -> IDLE; results held.
REQ-020 Datum processing, in the cycle after its address is issued (pipeline tag = issued address delayed one cycle).
REQ-021 datum > max_dist: max_dist<=datum, max_addr<=tag, max_count<=1.
REQ-022 datum == max_dist: max_count<=max_count+1; max_addr unchanged (first occurrence kept).
REQ-023 datum != 0: fg_count<=fg_count+1.
REQ-024 Comparisons unsigned 8-bit; counters 15-bit, max N_PIX, no wrap possible.
REQ-025 Latency: done rises N_PIX+2 cycles after the edge at which start=1 was sampled in IDLE (16386 for default).
REQ-026 start changes during READ/DRAIN ignored; scan always completes.
REQ-027 res_rd=0 and res_addr=0 in IDLE, DRAIN, DONE.
REQ-028 Outputs max_* and fg_count are registered, stable outside READ/DRAIN, and valid whenever done=1.
REQ-029 All-zero map: max_dist=0, max_addr=0, max_count=N_PIX, fg_count=0.

Reset
REQ-030 reset=0 at any time (including mid-scan) SHALL immediately force IDLE, res_rd=0, res_addr=0, busy=0, done=0, all result outputs 0.
REQ-031 After reset release, no scan begins until start=1 is sampled in IDLE.

Verification
REQ-032 All-zero memory, start=1 -> done after 16386 cycles; max_dist=0, max_addr=0, max_count=16384, fg_count=0.
REQ-033 Memory zero except addr 5000=7, addr 5001=3 -> max_dist=7, max_addr=5000, max_count=1, fg_count=2.
REQ-034 addr 300=12, addr 9000=12, addr 400=11 -> max_dist=12, max_addr=300, max_count=2, fg_count=3.
REQ-035 Only addr 16383=255 (drain-cycle datum) -> max_dist=255, max_addr=16383, max_count=1, fg_count=1.
REQ-036 reset pulsed when res_addr=8000 -> all outputs 0 asynchronously; re-assert start -> full scan from addr 0 with correct results.
REQ-037 start held high after done -> remains in DONE, no second res_rd; start low one cycle then high -> new scan, results cleared then recomputed.
